grom_alu: RTL and testbench
===========================

Name: grom_alu

Overview:
- 8-bit arithmetic/logic unit for the grom 8-bit CPU core.
- Takes operand A (CPU R0), operand B (a selected register) and a 5-bit operation code.
- Result and CF/ZF/SF flags are registered: available one clock after inputs are applied.
- Flags persist between operations and feed the CPU's conditional jumps.

Parameters:
- WIDTH, 8, data width of A, B and result. Flag and shift definitions assume bit WIDTH-1 is the sign bit.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- A  input  WIDTH  first operand
- B  input  WIDTH  second operand
- operation  input  5  operation code
- result  output  WIDTH  registered result
- CF  output  1  registered carry/borrow flag
- ZF  output  1  registered zero flag
- SF  output  1  registered sign flag

Behaviour:
- Clocking and reset:
  - Reset asserted (async): result=0, CF=0, ZF=0, SF=0 immediately. Outputs hold while reset is high.
  - Every rising clk edge with reset low: evaluate A, B, operation combinationally, then register result and flags.
  - Latency 1 clock; no handshake.
  - Inputs held constant re-evaluate every edge. ADC/SBC/RCL/RCR consume the current CF register, so the consumer must sample result exactly 1 cycle after applying inputs.
- Operation codes:
  - 00000 ADD: A+B
  - 00001 SUB: A-B
  - 00010 ADC: A+B+CF
  - 00011 SBC: A-B-CF
  - 00100 AND: A&B
  - 00101 OR: A|B
  - 00110 NOT: ~B
  - 00111 XOR: A^B
  - 01000 INC: B+1
  - 01001 DEC: B-1
  - 01010 CMP: A-B
  - 01011 TST: A&B
  - 10000 SHL: A<<1, bit0=0
  - 10001 SHR: logical right, MSB=0
  - 10010 SAL: same as SHL
  - 10011 SAR: arithmetic right, MSB kept
  - 10100 ROL: rotate left
  - 10101 ROR: rotate right
  - 10110 RCL: rotate left through CF
  - 10111 RCR: rotate right through CF
- CMP and TST drive result like SUB/AND. Discarding the value is the CPU's job.
- CF rules:
  - Add ops (ADD, ADC, INC): carry out of bit WIDTH-1. INC of 0xFF gives result 0x00, CF=1.
  - Subtract ops (SUB, SBC, DEC, CMP): borrow, i.e. 1 when the unsigned minuend < subtrahend (+CF for SBC). DEC of 0x00 gives 0xFF, CF=1.
  - Logic ops (AND, OR, NOT, XOR, TST): CF=0.
  - Shifts and rotates: CF = bit shifted out (left: old bit WIDTH-1; right: old bit 0).
- ZF = (result==0). SF = result[WIDTH-1]. Both updated for every defined operation.
- Undefined codes (01100–01111, 11xxx): result and all flags hold their previous values.
- All arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro GROM_ALU_OVERFLOW_EN.
- Defined: extra output OF (1 bit, reset 0) carries the two's-complement signed overflow.
  - ADD/ADC/INC: operands of equal sign, result of different sign.
  - SUB/SBC/DEC/CMP: operands of opposite sign, result sign differs from minuend.
  - SAL/SHL: OF = old bit7 XOR old bit6.
  - All others: OF=0.
  - Undefined codes hold OF.
- Undefined: no OF port; behaviour otherwise identical.

Decomposition:
- Package grom_alu_pkg: localparams for all 20 operation codes (OP_ADD … OP_RCR) and WIDTH default.
- One natural sub-module, grom_alu_shifter: combinational shift/rotate unit. Takes operand, operation[2:0] and carry-in; returns shifted value and carry-out.
- Top holds the add/sub, logic and flag registers.

Test Plan:
- Reset: assert reset mid-operation -> result=0x00, CF=ZF=SF=0 without waiting for a clk edge.
- ADD then ADC carry chain:
  - A=0xFF, B=0x01, op ADD -> next cycle result=0x00, CF=1, ZF=1, SF=0.
  - Next op ADC with A=0x10, B=0x20 -> result=0x31, CF=0, ZF=0.
- SUB/CMP borrow: A=0x05, B=0x07, op SUB -> result=0xFE, CF=1, SF=1, ZF=0. Op CMP with A=B=0x42 -> result=0x00, ZF=1, CF=0.
- INC/DEC wrap:
  - B=0xFF, op INC -> 0x00, CF=1, ZF=1.
  - B=0x00, op DEC -> 0xFF, CF=1, SF=1.
  - B=0x80, op NOT -> 0x7F, CF=0.
- Shifts with A=0x81:
  - SHR -> 0x40, CF=1
  - SAR -> 0xC0, CF=1
  - ROL -> 0x03, CF=1
  - RCR with CF=0 -> 0x40, CF=1
  - SHL -> 0x02, CF=1
- Undefined code 11010 after XOR A=0x0F, B=0x0F (result 0x00, ZF=1) -> result and flags unchanged for 3 cycles.

Source files
------------

// File: rtl/grom_alu_pkg.sv
// grom_alu_pkg: operation codes and default data width for the grom ALU
package grom_alu_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_SBC = 5'b00011;
  localparam logic [4:0] OP_AND = 5'b00100;
  localparam logic [4:0] OP_OR  = 5'b00101;
  localparam logic [4:0] OP_NOT = 5'b00110;
  localparam logic [4:0] OP_XOR = 5'b00111;
  localparam logic [4:0] OP_INC = 5'b01000;
  localparam logic [4:0] OP_DEC = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_TST = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b10001;
  localparam logic [4:0] OP_SAL = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;
endpackage

// File: rtl/grom_alu_shifter.sv
// grom_alu_shifter: combinational shift/rotate unit; op[0] selects right, op[2] selects rotate
module grom_alu_shifter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout
);
  logic fill;
  always_comb begin
    fill = op[2] ? (op[1] ? cin : (op[0] ? a[0] : a[WIDTH-1])) : (op[1] & op[0] & a[WIDTH-1]);
    y    = op[0] ? {fill, a[WIDTH-1:1]} : {a[WIDTH-2:0], fill};
    cout = op[0] ? a[0] : a[WIDTH-1];
  end
endmodule

// File: rtl/grom_alu.sv
// grom_alu: registered 8-bit ALU with CF/ZF/SF flags; GROM_ALU_OVERFLOW_EN adds a signed-overflow OF output
module grom_alu
  import grom_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             CF,
  output logic             ZF,
  output logic             SF
`ifdef GROM_ALU_OVERFLOW_EN
  ,
  output logic             OF
`endif
);
  logic [WIDTH-1:0] x, y, r, sh_y;
  logic [WIDTH:0]   sum;
  logic             cin, sub, c, valid, sh_c;
  grom_alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a(A), .op(operation[2:0]), .cin(CF), .y(sh_y), .cout(sh_c)
  );
  always_comb begin
    x   = (operation == OP_INC || operation == OP_DEC) ? B : A;
    y   = (operation == OP_INC || operation == OP_DEC) ? WIDTH'(1) : B;
    cin = (operation == OP_ADC || operation == OP_SBC) ? CF : 1'b0;
    sub = operation == OP_SUB || operation == OP_SBC || operation == OP_DEC || operation == OP_CMP;
    // the extra top bit is carry for adds and borrow for subtracts
    sum = sub ? {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin}
              : {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    r     = result;
    c     = CF;
    valid = 1'b1;
    case (operation)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_INC, OP_DEC, OP_CMP: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
      end
      OP_AND, OP_TST: begin r = A & B; c = 1'b0; end
      OP_OR:          begin r = A | B; c = 1'b0; end
      OP_NOT:         begin r = ~B;    c = 1'b0; end
      OP_XOR:         begin r = A ^ B; c = 1'b0; end
      OP_SHL, OP_SHR, OP_SAL, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
        r = sh_y;
        c = sh_c;
      end
      default: valid = 1'b0;
    endcase
  end
`ifdef GROM_ALU_OVERFLOW_EN
  logic o;
  always_comb begin
    o = 1'b0;
    case (operation)
      OP_ADD, OP_ADC, OP_INC:         o = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      OP_SUB, OP_SBC, OP_DEC, OP_CMP: o = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      OP_SHL, OP_SAL:                 o = A[WIDTH-1] ^ A[WIDTH-2];
      default:                        o = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) OF <= 1'b0;
    else if (valid) OF <= o;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      CF     <= 1'b0;
      ZF     <= 1'b0;
      SF     <= 1'b0;
    end else if (valid) begin
      result <= r;
      CF     <= c;
      ZF     <= r == '0;
      SF     <= r[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_grom_alu.sv
// tb_grom_alu: directed self-checking bench for grom_alu
module tb_grom_alu;
  import grom_alu_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] A = '0, B = '0;
  logic [4:0] operation = OP_ADD;
  logic [7:0] result;
  logic       CF, ZF, SF;
  int         checks = 0, errors = 0;
`ifdef GROM_ALU_OVERFLOW_EN
  logic OF;
`endif

  grom_alu dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .operation(operation),
    .result(result), .CF(CF), .ZF(ZF), .SF(SF)
`ifdef GROM_ALU_OVERFLOW_EN
    , .OF(OF)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
    A = a; B = b; operation = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({result, CF, ZF, SF} !== 11'h000) begin
      errors++; $display("FAIL reset_initial got %h exp %h", {result, CF, ZF, SF}, 11'h000);
    end
    reset = 1'b0;
    step(8'h7F, 8'h01, OP_ADD);
    checks++;
    if ({result, CF, ZF, SF} !== {8'h80, 3'b001}) begin
      errors++; $display("FAIL pre_reset_add got %h exp %h", {result, CF, ZF, SF}, {8'h80, 3'b001});
    end
    step(8'hFF, 8'h01, OP_ADD);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({result, CF, ZF, SF} !== 11'h000) begin
      errors++; $display("FAIL reset_async got %h exp %h", {result, CF, ZF, SF}, 11'h000);
    end
    @(posedge clk); #1;
    checks++;
    if ({result, CF, ZF, SF} !== 11'h000) begin
      errors++; $display("FAIL reset_hold got %h exp %h", {result, CF, ZF, SF}, 11'h000);
    end
    reset = 1'b0;
  endtask

  // each row: A, B, op, expected {result, CF, ZF, SF}
  task automatic test_arith;
    logic [7:0]  va [9] = '{8'hFF, 8'h10, 8'h05, 8'h42, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10};
    logic [7:0]  vb [9] = '{8'h01, 8'h20, 8'h07, 8'h42, 8'hFF, 8'h00, 8'h80, 8'h05, 8'h05};
    logic [4:0]  vo [9] = '{OP_ADD, OP_ADC, OP_SUB, OP_CMP, OP_INC, OP_DEC, OP_NOT, OP_SBC, OP_SBC};
    logic [10:0] ve [9] = '{{8'h00, 3'b110}, {8'h31, 3'b000}, {8'hFE, 3'b101}, {8'h00, 3'b010},
                            {8'h00, 3'b110}, {8'hFF, 3'b101}, {8'h7F, 3'b000}, {8'h0B, 3'b000},
                            {8'h0B, 3'b000}};
    for (int i = 0; i < 9; i++) begin
      step(va[i], vb[i], vo[i]);
      checks++;
      if ({result, CF, ZF, SF} !== ve[i]) begin
        errors++; $display("FAIL arith[%0d] op %b got %h exp %h", i, vo[i], {result, CF, ZF, SF}, ve[i]);
      end
    end
  endtask

  task automatic test_shifts;
    logic [4:0]  vo [11] = '{OP_AND, OP_SHR, OP_SAR, OP_ROL, OP_AND, OP_RCR, OP_SHL, OP_RCL,
                             OP_ROR, OP_SAL, OP_RCL};
    logic [7:0]  vb [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [10:0] ve [11] = '{{8'h00, 3'b010}, {8'h40, 3'b100}, {8'hC0, 3'b101}, {8'h03, 3'b100},
                             {8'h00, 3'b010}, {8'h40, 3'b100}, {8'h02, 3'b100}, {8'h03, 3'b100},
                             {8'hC0, 3'b101}, {8'h02, 3'b100}, {8'h03, 3'b100}};
    for (int i = 0; i < 11; i++) begin
      step(8'h81, vb[i], vo[i]);
      checks++;
      if ({result, CF, ZF, SF} !== ve[i]) begin
        errors++; $display("FAIL shift[%0d] op %b got %h exp %h", i, vo[i], {result, CF, ZF, SF}, ve[i]);
      end
    end
  endtask

  task automatic test_undefined;
    logic [4:0] vo [4] = '{5'b11010, 5'b11010, 5'b11010, 5'b01100};
    step(8'h0F, 8'h0F, OP_XOR);
    checks++;
    if ({result, CF, ZF, SF} !== {8'h00, 3'b010}) begin
      errors++; $display("FAIL xor_zero got %h exp %h", {result, CF, ZF, SF}, {8'h00, 3'b010});
    end
    for (int i = 0; i < 4; i++) begin
      step(8'hFF, 8'h81, vo[i]);
      checks++;
      if ({result, CF, ZF, SF} !== {8'h00, 3'b010}) begin
        errors++; $display("FAIL undef_hold[%0d] got %h exp %h", i, {result, CF, ZF, SF}, {8'h00, 3'b010});
      end
    end
  endtask

`ifdef GROM_ALU_OVERFLOW_EN
  task automatic test_overflow;
    logic [7:0] va [5] = '{8'h7F, 8'h80, 8'h40, 8'hFF, 8'h01};
    logic [7:0] vb [5] = '{8'h01, 8'h01, 8'h00, 8'hFF, 8'h01};
    logic [4:0] vo [5] = '{OP_ADD, OP_SUB, OP_SHL, OP_AND, OP_ADD};
    logic       ve [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(va[i], vb[i], vo[i]);
      checks++;
      if (OF !== ve[i]) begin
        errors++; $display("FAIL overflow[%0d] OF got %b exp %b", i, OF, ve[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_shifts();
    test_undefined();
`ifdef GROM_ALU_OVERFLOW_EN
    test_overflow();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
